// File: rtl/tm1638_if.sv
// TM1638 three-wire pin bundle (STB, CLK, DIO split into drive/sense halves).
// The host side uses master; the chip-side responder uses slave.
interface tm1638_if;
  logic tm1638_strobe;
  logic tm1638_clk;
  logic tm1638_data_in;
  logic tm1638_data_out;
  logic tm1638_data_oe;

  modport master (
    output tm1638_strobe,
    output tm1638_clk,
    output tm1638_data_in,
    input  tm1638_data_out,
    input  tm1638_data_oe
  );

  modport slave (
    input  tm1638_strobe,
    input  tm1638_clk,
    input  tm1638_data_in,
    output tm1638_data_out,
    output tm1638_data_oe
  );
endinterface

// File: rtl/tm1638_responder.sv
// TM1638 chip-side responder: decodes host STB/CLK/DIO frames, keeps the 16-byte
// display RAM and display control, and shifts out 4 key-scan bytes on read commands.
module tm1638_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  tm1638_if.slave    bus,
  input  logic [7:0] keys,
  input  logic [3:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       display_on,
  output logic [2:0] display_level,
  output logic       frame_done,
  output logic       proto_err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  // Byte n carries S(n+1) in bit 0 and S(n+5) in bit 4; all other bits are zero.
  function automatic logic [31:0] key_frame(input logic [7:0] k);
    logic [31:0] f;
    f = 32'd0;
    for (int n = 0; n < 4; n++) begin
      f[n*8]     = k[7-n];
      f[n*8 + 4] = k[3-n];
    end
    return f;
  endfunction

  logic [SYNC_STAGES-1:0] stb_sync_r;
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] din_sync_r;
  logic                   stb_prev_r;
  logic                   sclk_prev_r;

  state_t      state_r;
  logic [2:0]  bit_cnt_r;
  logic [6:0]  shift_r;
  logic [3:0]  addr_r;
  logic        fixed_r;
  logic        wrote_r;
  logic [30:0] key_sr_r;
  logic        dout_r;
  logic        oe_r;
  logic [7:0]  ram_r [16];
  logic [7:0]  ram_data_r;
  logic        disp_on_r;
  logic [2:0]  disp_lvl_r;
  logic        frame_done_r;
  logic        proto_err_r;

  logic        stb_now_s;
  logic        sclk_now_s;
  logic        din_now_s;
  logic        stb_fall_s;
  logic        stb_rise_s;
  logic        sclk_rise_s;
  logic        sclk_fall_s;
  logic [7:0]  byte_s;
  logic [31:0] key_frame_s;

  // Pad synchronizers; STB and SCLK idle high so they reset high to avoid false edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_sync_r  <= {SYNC_STAGES{1'b1}};
      sclk_sync_r <= {SYNC_STAGES{1'b1}};
      din_sync_r  <= {SYNC_STAGES{1'b0}};
      stb_prev_r  <= 1'b1;
      sclk_prev_r <= 1'b1;
    end else begin
      stb_sync_r  <= {stb_sync_r[SYNC_STAGES-2:0], bus.tm1638_strobe};
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], bus.tm1638_clk};
      din_sync_r  <= {din_sync_r[SYNC_STAGES-2:0], bus.tm1638_data_in};
      stb_prev_r  <= stb_now_s;
      sclk_prev_r <= sclk_now_s;
    end
  end

  // Edge detection on synchronized pins; SCLK edges only count inside a frame.
  always_comb begin
    stb_now_s   = stb_sync_r[SYNC_STAGES-1];
    sclk_now_s  = sclk_sync_r[SYNC_STAGES-1];
    din_now_s   = din_sync_r[SYNC_STAGES-1];
    stb_fall_s  = stb_prev_r & ~stb_now_s;
    stb_rise_s  = ~stb_prev_r & stb_now_s;
    sclk_rise_s = ~stb_now_s & ~sclk_prev_r & sclk_now_s;
    sclk_fall_s = ~stb_now_s & sclk_prev_r & ~sclk_now_s;
    byte_s      = {din_now_s, shift_r};
    key_frame_s = key_frame(keys);
  end

  // Frame FSM, RAM, display control and key shift-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 7'd0;
      addr_r       <= 4'd0;
      fixed_r      <= 1'b0;
      wrote_r      <= 1'b0;
      key_sr_r     <= 31'd0;
      dout_r       <= 1'b0;
      oe_r         <= 1'b0;
      ram_data_r   <= 8'd0;
      disp_on_r    <= 1'b0;
      disp_lvl_r   <= 3'd0;
      frame_done_r <= 1'b0;
      proto_err_r  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        ram_r[i] <= 8'd0;
      end
    end else begin
      frame_done_r <= 1'b0;
      proto_err_r  <= 1'b0;
      ram_data_r   <= ram_r[ram_addr];
      if (stb_fall_s) begin
        state_r   <= ST_CMD;
        bit_cnt_r <= 3'd0;
        wrote_r   <= 1'b0;
        oe_r      <= 1'b0;
        dout_r    <= 1'b0;
      end else if (stb_rise_s) begin
        state_r      <= ST_IDLE;
        bit_cnt_r    <= 3'd0;
        oe_r         <= 1'b0;
        dout_r       <= 1'b0;
        frame_done_r <= wrote_r;
        proto_err_r  <= (bit_cnt_r != 3'd0);
      end else begin
        case (state_r)
          ST_CMD, ST_WDATA, ST_HOLD: begin
            if (sclk_rise_s) begin
              shift_r   <= {din_now_s, shift_r[6:1]};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                case (state_r)
                  ST_CMD: begin
                    case (byte_s[7:6])
                      2'b01: begin
                        fixed_r <= byte_s[2];
                        if (byte_s[1]) begin
                          state_r  <= ST_RDATA;
                          key_sr_r <= key_frame_s[31:1];
                          dout_r   <= key_frame_s[0];
                          oe_r     <= 1'b1;
                        end else begin
                          state_r <= ST_HOLD;
                        end
                      end
                      2'b10: begin
                        disp_on_r  <= byte_s[3];
                        disp_lvl_r <= byte_s[2:0];
                        state_r    <= ST_HOLD;
                      end
                      2'b11: begin
                        addr_r  <= byte_s[3:0];
                        state_r <= ST_WDATA;
                      end
                      default: state_r <= ST_HOLD;
                    endcase
                  end
                  ST_WDATA: begin
                    ram_r[addr_r] <= byte_s;
                    wrote_r       <= 1'b1;
                    if (!fixed_r) begin
                      addr_r <= addr_r + 4'd1;
                    end else begin
                      addr_r <= addr_r;
                    end
                  end
                  default: ;
                endcase
              end
            end
          end
          // Zeros shift in behind the key bits, so DIO reads 0 once all 32 are out.
          ST_RDATA: begin
            if (sclk_fall_s) begin
              dout_r   <= key_sr_r[0];
              key_sr_r <= {1'b0, key_sr_r[30:1]};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.tm1638_data_out = dout_r;
  assign bus.tm1638_data_oe  = oe_r;
  assign ram_data            = ram_data_r;
  assign display_on          = disp_on_r;
  assign display_level       = disp_lvl_r;
  assign frame_done          = frame_done_r;
  assign proto_err           = proto_err_r;

endmodule

// File: tb/tb_tm1638_responder.sv
// Bench for tm1638_responder: directed frames plus random traffic, checked against
// a frame-level model of RAM, address mode, display control and key bytes.
module tb_tm1638_responder;
  localparam int H = 6;

  logic       clk;
  logic       rst;
  logic [7:0] keys;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       display_on;
  logic [2:0] display_level;
  logic       frame_done;
  logic       proto_err;

  tm1638_if bus();

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .keys(keys), .ram_addr(ram_addr),
    .ram_data(ram_data), .display_on(display_on), .display_level(display_level),
    .frame_done(frame_done), .proto_err(proto_err)
  );

  int vectors = 0;
  int miscompares = 0;
  int fd_cnt = 0;
  int pe_cnt = 0;

  logic [7:0] m_ram [16];
  logic       m_fixed;
  logic       m_on;
  logic [2:0] m_lvl;
  logic [7:0] wq [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (proto_err)  pe_cnt <= pe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic stb_low();
    bus.tm1638_strobe = 1'b0;
    cyc(H);
  endtask

  task automatic stb_high();
    bus.tm1638_strobe = 1'b1;
    cyc(H + 2);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      bus.tm1638_clk     = 1'b0;
      bus.tm1638_data_in = b[i];
      cyc(H);
      bus.tm1638_clk = 1'b1;
      cyc(H);
    end
  endtask

  task automatic read_byte(output logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      b[i] = bus.tm1638_data_out;
      bus.tm1638_clk = 1'b0;
      cyc(H);
      bus.tm1638_clk = 1'b1;
      cyc(H);
    end
  endtask

  task automatic check_ram();
    for (int k = 0; k < 16; k++) begin
      ram_addr = 4'(k);
      cyc(2);
      check($sformatf("ram[%0d]", k), {24'd0, ram_data}, {24'd0, m_ram[k]});
    end
  endtask

  task automatic check_disp();
    check("display_on", {31'd0, display_on}, {31'd0, m_on});
    check("display_level", {29'd0, display_level}, {29'd0, m_lvl});
  endtask

  // Address-set frame: command, the bytes queued in wq, then an optional partial byte.
  task automatic write_frame(input logic [3:0] a, input int partial);
    int fd0;
    int pe0;
    logic [3:0] p;
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    p = a;
    stb_low();
    send_bits({2'b11, 2'($urandom_range(0, 3)), a}, 8);
    foreach (wq[i]) begin
      send_bits(wq[i], 8);
      m_ram[p] = wq[i];
      if (!m_fixed) p = p + 4'd1;
    end
    if (partial > 0) send_bits(8'($urandom), partial);
    stb_high();
    check("frame_done", 32'(fd_cnt - fd0), (wq.size() > 0) ? 32'd1 : 32'd0);
    check("proto_err", 32'(pe_cnt - pe0), (partial > 0) ? 32'd1 : 32'd0);
  endtask

  // Data (write), display or ignored command followed by discarded bytes.
  task automatic simple_cmd(input logic [7:0] cmd, input int extra);
    int fd0;
    int pe0;
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    stb_low();
    send_bits(cmd, 8);
    for (int i = 0; i < extra; i++) send_bits(8'($urandom), 8);
    stb_high();
    if (cmd[7:6] == 2'b01) m_fixed = cmd[2];
    if (cmd[7:6] == 2'b10) begin
      m_on  = cmd[3];
      m_lvl = cmd[2:0];
    end
    check("cmd_frame_done", 32'(fd_cnt - fd0), 32'd0);
    check("cmd_proto_err", 32'(pe_cnt - pe0), 32'd0);
    check_disp();
  endtask

  task automatic read_frame(input logic [7:0] k, input logic [7:0] cmd);
    logic [7:0] got;
    logic [7:0] exp;
    int fd0;
    int pe0;
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    keys = k;
    stb_low();
    send_bits(cmd, 8);
    m_fixed = cmd[2];
    keys = 8'($urandom);
    for (int n = 0; n < 4; n++) begin
      read_byte(got);
      exp = 8'd0;
      exp[0] = k[7-n];
      exp[4] = k[3-n];
      check($sformatf("key_byte%0d", n), {24'd0, got}, {24'd0, exp});
    end
    check("dout_after_32", {31'd0, bus.tm1638_data_out}, 32'd0);
    send_bits(8'hFF, 2);
    check("oe_in_frame", {31'd0, bus.tm1638_data_oe}, 32'd1);
    stb_high();
    check("oe_after_stb", {31'd0, bus.tm1638_data_oe}, 32'd0);
    check("read_frame_done", 32'(fd_cnt - fd0), 32'd0);
    check("read_proto_err", 32'(pe_cnt - pe0), 32'd0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_ram[k] = 8'd0;
    m_fixed = 1'b0;
    m_on    = 1'b0;
    m_lvl   = 3'd0;
  endtask

  initial begin
    logic [7:0] got;
    int op;
    int n;
    rst = 1'b1;
    keys = 8'd0;
    ram_addr = 4'd0;
    bus.tm1638_strobe  = 1'b1;
    bus.tm1638_clk     = 1'b1;
    bus.tm1638_data_in = 1'b0;
    model_reset();
    cyc(4);
    check("rst_oe", {31'd0, bus.tm1638_data_oe}, 32'd0);
    check("rst_dout", {31'd0, bus.tm1638_data_out}, 32'd0);
    check("rst_pulses", {30'd0, frame_done, proto_err}, 32'd0);
    check_disp();
    rst = 1'b0;
    cyc(4);
    check_ram();

    // Auto-increment fill of the whole RAM.
    simple_cmd(8'h40, 0);
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back(8'(i));
    write_frame(4'd0, 0);
    check_ram();

    // Fixed address, then auto-increment wrap from 15 to 0.
    simple_cmd(8'h44, 0);
    wq = '{8'hAA, 8'hBB};
    write_frame(4'd5, 0);
    simple_cmd(8'h40, 0);
    wq = '{8'h11, 8'h22};
    write_frame(4'd15, 0);
    check_ram();

    read_frame(8'b1000_0001, 8'h42);

    simple_cmd(8'h8B, 2);
    simple_cmd(8'h80, 0);
    check_ram();

    // Partial byte: with and without an earlier complete byte.
    wq.delete();
    write_frame(4'd0, 5);
    wq = '{8'h5A};
    write_frame(4'd3, 5);
    check_ram();

    // Reset in the middle of a key read.
    simple_cmd(8'h8D, 0);
    keys = 8'hA5;
    stb_low();
    send_bits(8'h42, 8);
    read_byte(got);
    rst = 1'b1;
    cyc(1);
    check("midrst_oe", {31'd0, bus.tm1638_data_oe}, 32'd0);
    check("midrst_on", {31'd0, display_on}, 32'd0);
    check("midrst_lvl", {29'd0, display_level}, 32'd0);
    cyc(1);
    rst = 1'b0;
    model_reset();
    n = pe_cnt + fd_cnt;
    stb_high();
    check("midrst_pulses", 32'(pe_cnt + fd_cnt - n), 32'd0);
    check_ram();
    wq = '{8'h3C, 8'hC3, 8'h7E};
    write_frame(4'd9, 0);
    check_ram();

    // Random traffic.
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          wq.delete();
          n = $urandom_range(0, 5);
          for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
          write_frame(4'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
        end
        1: simple_cmd({2'b01, 3'($urandom), 1'($urandom), 1'b0, 1'($urandom)}, $urandom_range(0, 2));
        2: simple_cmd({2'b10, 6'($urandom)}, 0);
        3: read_frame(8'($urandom), {2'b01, 3'($urandom), 1'($urandom), 1'b1, 1'($urandom)});
        default: simple_cmd({2'b00, 6'($urandom)}, $urandom_range(0, 2));
      endcase
    end
    check_ram();
    check_disp();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
